// File: rtl/sd_spi_card_responder.sv
// sd_spi_card_responder: SPI-mode SD card emulator serving R1/R7 responses and single-block reads/writes from external RAM
module sd_spi_card_responder #(
    parameter int NUM_BLOCKS = 1024,
    parameter int ADDR_W     = 19,
    parameter int INIT_POLLS = 2,
    parameter int BUSY_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              sclk,
    input  logic              mosi,
    output logic              miso,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data,
    output logic [31:0]       debug
);
    typedef enum logic [3:0] {
        IDLE, CMD_RX, NCR, RESP, RD_GAP, RD_TOK, RD_DATA, RD_CRC,
        WR_TOK, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
    } state_t;

    state_t      state, state_n;
    logic [9:0]  cnt, cnt_n;
    logic        cs_m, cs_s, sclk_m, sclk_s, sclk_d, mosi_m, mosi_s;
    logic        rise, fall, byte_done;
    logic [2:0]  bit_cnt;
    logic [6:0]  rx_sr;
    logic [7:0]  rx_byte, tx_shift, tx_byte, tx_next;
    logic        rd_pend;
    logic [5:0]  cmd, last_cmd;
    logic [31:0] arg;
    logic        in_idle, app_cmd, acmd41, blk_bad;
    logic [7:0]  poll_cnt, last_r1, cmd_count, r1_d;
    logic        dec, wr_now, rd_now;
    logic [8:0]  rd_off;

    assign rise      = sclk_s & ~sclk_d;
    assign fall      = ~sclk_s & sclk_d;
    assign byte_done = rise & ~cs_s & (bit_cnt == 3'd7);
    assign rx_byte   = {rx_sr, mosi_s};
    assign miso      = cs_s | tx_shift[7];
    assign debug     = {4'b0, state, 2'b0, last_cmd, last_r1, cmd_count};
    assign blk_bad   = arg >= 32'(NUM_BLOCKS);
    assign acmd41    = (cmd == 6'd41) & app_cmd;

    // Bring the asynchronous SPI pins into the clk domain; sclk_d gives edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            {cs_m, cs_s} <= 2'b11;
            {sclk_m, sclk_s, sclk_d} <= 3'b000;
            {mosi_m, mosi_s} <= 2'b00;
        end else begin
            {cs_m, cs_s} <= {cs, cs_m};
            {sclk_m, sclk_s, sclk_d} <= {sclk, sclk_m, sclk_s};
            {mosi_m, mosi_s} <= {mosi, mosi_m};
        end
    end

    // Bit-level shifting: receive on rises, reload TX on the 8th rise, shift TX on falls inside a byte
    always_ff @(posedge clk) begin
        if (rst || cs_s) begin
            bit_cnt  <= 3'd0;
            rx_sr    <= 7'd0;
            tx_shift <= 8'hFF;
        end else begin
            if (rise) begin
                rx_sr   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done)
                tx_shift <= tx_byte;
            else if (fall && bit_cnt != 3'd0)
                tx_shift <= {tx_shift[6:0], 1'b1};
        end
    end

    // Byte-level protocol state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 10'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next state, next TX byte, command decode and RAM strobes; decisions happen once per completed byte
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tx_byte = 8'hFF;
        dec     = 1'b0;
        wr_now  = 1'b0;
        rd_now  = rise && !cs_s && bit_cnt == 3'd0 &&
                  (state == RD_TOK || (state == RD_DATA && cnt != 10'd511));
        rd_off  = state == RD_TOK ? 9'd0 : cnt[8:0] + 9'd1;
        r1_d    = cmd == 6'd0 ? 8'h01 :
                  (cmd == 6'd8 || cmd == 6'd16 || cmd == 6'd55) ? {7'b0, in_idle} :
                  acmd41 ? {7'b0, poll_cnt < 8'(INIT_POLLS)} :
                  (cmd == 6'd17 || cmd == 6'd24) ? (in_idle ? 8'h05 : blk_bad ? 8'h40 : 8'h00) :
                  {5'b0, 1'b1, 1'b0, in_idle};
        if (cs_s) begin
            state_n = IDLE;
            cnt_n   = 10'd0;
        end else if (byte_done) begin
            case (state)
                IDLE: if (rx_byte[7:6] == 2'b01) begin
                    state_n = CMD_RX;
                    cnt_n   = 10'd1;
                end
                CMD_RX: if (cnt == 10'd5) begin
                    state_n = NCR;
                    cnt_n   = 10'd0;
                    dec     = 1'b1;
                end else cnt_n = cnt + 10'd1;
                NCR: begin
                    state_n = RESP;
                    cnt_n   = 10'd0;
                    tx_byte = last_r1;
                end
                RESP: if (last_cmd == 6'd8 && cnt < 10'd4) begin
                    tx_byte = cnt == 10'd3 ? arg[7:0] : cnt == 10'd2 ? 8'h01 : 8'h00;
                    cnt_n   = cnt + 10'd1;
                end else begin
                    cnt_n   = 10'd0;
                    state_n = (last_cmd == 6'd17 && last_r1 == 8'h00) ? RD_GAP :
                              (last_cmd == 6'd24 && last_r1 == 8'h00) ? WR_TOK : IDLE;
                end
                RD_GAP: begin
                    state_n = RD_TOK;
                    tx_byte = 8'hFE;
                end
                RD_TOK: begin
                    state_n = RD_DATA;
                    cnt_n   = 10'd0;
                    tx_byte = tx_next;
                end
                RD_DATA: if (cnt == 10'd511) begin
                    state_n = RD_CRC;
                    cnt_n   = 10'd0;
                end else begin
                    tx_byte = tx_next;
                    cnt_n   = cnt + 10'd1;
                end
                RD_CRC: if (cnt == 10'd1) begin
                    state_n = IDLE;
                    cnt_n   = 10'd0;
                end else cnt_n = cnt + 10'd1;
                WR_TOK: if (rx_byte == 8'hFE) begin
                    state_n = WR_DATA;
                    cnt_n   = 10'd0;
                end
                WR_DATA: begin
                    wr_now = 1'b1;
                    if (cnt == 10'd511) begin
                        state_n = WR_CRC;
                        cnt_n   = 10'd0;
                    end else cnt_n = cnt + 10'd1;
                end
                WR_CRC: if (cnt == 10'd1) begin
                    state_n = WR_RESP;
                    cnt_n   = 10'd0;
                    tx_byte = 8'h05;
                end else cnt_n = cnt + 10'd1;
                WR_RESP: begin
                    state_n = WR_BUSY;
                    cnt_n   = 10'd0;
                    tx_byte = 8'h00;
                end
                WR_BUSY: if (cnt == 10'(BUSY_BYTES - 1)) begin
                    state_n = IDLE;
                    cnt_n   = 10'd0;
                end else begin
                    tx_byte = 8'h00;
                    cnt_n   = cnt + 10'd1;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Command capture and card-level status; in_idle/poll_cnt survive cs deassertion
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd       <= 6'd0;
            arg       <= 32'd0;
            in_idle   <= 1'b1;
            poll_cnt  <= 8'd0;
            app_cmd   <= 1'b0;
            last_cmd  <= 6'd0;
            last_r1   <= 8'd0;
            cmd_count <= 8'd0;
        end else begin
            if (byte_done && state == IDLE && rx_byte[7:6] == 2'b01)
                cmd <= rx_byte[5:0];
            if (byte_done && state == CMD_RX && cnt <= 10'd4)
                arg <= {arg[23:0], rx_byte};
            if (dec) begin
                last_cmd  <= cmd;
                last_r1   <= r1_d;
                cmd_count <= cmd_count + 8'd1;
                app_cmd   <= cmd == 6'd55;
                if (cmd == 6'd0) begin
                    in_idle  <= 1'b1;
                    poll_cnt <= 8'd0;
                end
                if (acmd41) begin
                    if (poll_cnt < 8'(INIT_POLLS))
                        poll_cnt <= poll_cnt + 8'd1;
                    else
                        in_idle <= 1'b0;
                end
            end
        end
    end

    // RAM port: read prefetch one byte ahead, writes on each data byte's 8th rise
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr    <= '0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_data <= 8'd0;
            rd_pend     <= 1'b0;
            tx_next     <= 8'hFF;
        end else begin
            mem_rd_en <= rd_now;
            mem_wr_en <= wr_now;
            rd_pend   <= mem_rd_en;
            if (rd_pend)
                tx_next <= mem_rd_data;
            if (rd_now)
                mem_addr <= {arg[ADDR_W-10:0], rd_off};
            if (wr_now) begin
                mem_addr    <= {arg[ADDR_W-10:0], cnt[8:0]};
                mem_wr_data <= rx_byte;
            end
        end
    end
endmodule
